model_buffer: RTL and testbench
===============================

Name: model_buffer

Overview:
- Triangle store for all loaded models.
- Loaded by the host/SPI command path through a write stream.
- Serves indexed triangle reads to the scene reader, returning one triangle per request with a per-model last flag.
- Sits directly upstream of the scene reader. It consumes that stage's (model_index, triangle_index) requests and produces its triangle + last stream.

Parameters:
- MAX_MODEL_COUNT, 10, number of model slots.
- MAX_TRIANGLE_COUNT, 100, triangle capacity per model slot.
- TRI_W, 288, triangle payload width in bits (3 vertices x 3 coords x 32 bit).
- IDX_W, 16, width of model and triangle index fields.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  synchronous reset, active-high (asserted = 1); name kept for codebase consistency.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted when high with wr_valid.
- wr_model_index  in  IDX_W  target model slot.
- wr_triangle_index  in  IDX_W  target triangle slot within model.
- wr_data  in  TRI_W  triangle payload.
- wr_last  in  1  this beat is the model's final triangle.
- wr_error  out  1  sticky: an out-of-range write was dropped.
- req_valid  in  1  read request valid.
- req_ready  out  1  read request accepted.
- req_model_index  in  IDX_W  model slot to read.
- req_triangle_index  in  IDX_W  triangle to read.
- out_valid  out  1  response valid.
- out_ready  in  1  downstream accepts response.
- out_data  out  TRI_W  triangle payload.
- out_last  out  1  triangle is last of model, or request was out of range.
- out_error  out  1  request was out of range; out_data is zero.

Behaviour:
- Storage:
  - Flat RAM of MAX_MODEL_COUNT*MAX_TRIANGLE_COUNT x TRI_W words.
  - Address = model*MAX_TRIANGLE_COUNT + triangle.
  - Per-model count register, width IDX_W; 0 means empty/invalid.
- Reset, while rstn=1 at a clock edge:
  - All counts cleared to 0; RAM contents not cleared.
  - out_valid=0, out_data=0, out_last=0, out_error=0, wr_error=0.
  - wr_ready=0 and req_ready=0 while rstn is high.
  - A reset mid-response discards that response; no beat is emitted afterward for it.
- Write path:
  - wr_ready=1 whenever not in reset.
  - Beat fires on wr_valid&&wr_ready.
  - If model >= MAX_MODEL_COUNT or triangle >= MAX_TRIANGLE_COUNT: beat dropped, wr_error set (sticky until reset), no count change.
  - Otherwise the RAM word is written.
  - triangle_index==0: count[model] set to 0, marking the model invalid during reload.
  - wr_last: count[model] set to triangle_index+1.
  - wr_last on index 0: count becomes 1 (index-0 clear and last-update combine).
- Read path:
  - Single-stage registered pipeline.
  - req_ready = !out_valid || out_ready (combinational from out_ready).
  - Request accepted at edge N gives out_valid=1 after edge N, i.e. latency 1.
  - Full throughput: one response per cycle when out_ready is held high.
  - out_valid, out_data, out_last, out_error are held stable while out_valid && !out_ready.
  - out_valid clears on a handshake with no new request accepted.
- Range check, using count values registered before any same-cycle write update:
  - In range iff model < MAX_MODEL_COUNT and triangle < count[model].
  - In range: out_data = RAM word; out_last = (triangle == count[model]-1); out_error=0.
  - Out of range, including an empty model: out_data=0, out_last=1, out_error=1. The downstream stage terminates cleanly on over-fetch.
- Same-cycle write and read to the same address: read returns the old contents (read-first).

Test Plan:
- Reset, then write model 2, triangles 0..2 (data 0xA0, 0xA1, 0xA2), last on 2; read (2,0), (2,1), (2,2) back-to-back with out_ready=1 -> out_valid on 3 consecutive cycles; data A0/A1/A2; out_last 0/0/1; out_error 0.
- Read (2,3) after the above -> out_data=0, out_last=1, out_error=1; read (5,0) on never-loaded model 5 -> same response.
- Backpressure: out_ready=0 for 4 cycles with req_valid held on (2,1) after a (2,0) response -> req_ready=0; out_data stays A0; on out_ready=1 the next cycle shows A1; no request lost or duplicated.
- Reload: write (2,0) data 0xB0 without last, then read (2,0) -> out_error=1; write (2,0) with last -> read (2,0) gives 0xB0, out_last=1.
- Write (10,0) and (0,100) -> both dropped, wr_error=1 and stays 1; counts unchanged; reset clears wr_error.
- Same-cycle write 0xC1 to (2,1) and read (2,1) -> response A1; next read (2,1) gives C1. Reset asserted while out_valid=1 -> out_valid=0 next cycle; all counts 0.

Source files
------------

// File: rtl/model_buffer.sv
// Triangle store for all loaded models: a streamed write port fills per-model
// slots, and an indexed read port returns one triangle per request with a last flag.
module model_buffer #(
    parameter int MAX_MODEL_COUNT    = 10,
    parameter int MAX_TRIANGLE_COUNT = 100,
    parameter int TRI_W              = 288,
    parameter int IDX_W              = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_model_index,
    input  logic [IDX_W-1:0] wr_triangle_index,
    input  logic [TRI_W-1:0] wr_data,
    input  logic             wr_last,
    output logic             wr_error,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_model_index,
    input  logic [IDX_W-1:0] req_triangle_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TRI_W-1:0] out_data,
    output logic             out_last,
    output logic             out_error
);

    localparam int DEPTH = MAX_MODEL_COUNT * MAX_TRIANGLE_COUNT;
    localparam int AW    = $clog2(DEPTH);
    localparam int MW    = (MAX_MODEL_COUNT > 1) ? $clog2(MAX_MODEL_COUNT) : 1;

    logic [TRI_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0] count_q [MAX_MODEL_COUNT];
    logic [IDX_W-1:0] count_d [MAX_MODEL_COUNT];

    logic             wr_error_q, wr_error_d;
    logic             out_valid_q, out_valid_d;
    logic [TRI_W-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_error_q, out_error_d;

    logic             wr_fire, wr_ok;
    logic [MW-1:0]    wr_mdl;
    logic [AW-1:0]    wr_addr;
    logic             req_fire, rd_mdl_ok, rd_ok;
    logic [MW-1:0]    rd_mdl;
    logic [IDX_W-1:0] rd_cnt;
    logic [AW-1:0]    rd_addr;

    assign wr_ready  = !rstn;
    assign req_ready = !rstn && (!out_valid_q || out_ready);

    assign wr_fire = wr_valid && wr_ready;
    assign wr_ok   = (wr_model_index < IDX_W'(MAX_MODEL_COUNT))
                  && (wr_triangle_index < IDX_W'(MAX_TRIANGLE_COUNT));
    assign wr_mdl  = MW'(wr_model_index);
    assign wr_addr = AW'(wr_mdl) * AW'(MAX_TRIANGLE_COUNT) + AW'(wr_triangle_index);

    always_comb begin
        count_d    = count_q;
        wr_error_d = wr_error_q;
        if (wr_fire) begin
            if (!wr_ok) begin
                wr_error_d = 1'b1;
            end else begin
                if (wr_triangle_index == '0)
                    count_d[wr_mdl] = '0;
                if (wr_last)
                    count_d[wr_mdl] = wr_triangle_index + IDX_W'(1);
            end
        end
    end

    // Range check uses the registered counts, so a same-cycle write has no effect
    assign req_fire  = req_valid && req_ready;
    assign rd_mdl_ok = req_model_index < IDX_W'(MAX_MODEL_COUNT);
    assign rd_mdl    = rd_mdl_ok ? MW'(req_model_index) : '0;
    assign rd_cnt    = count_q[rd_mdl];
    assign rd_ok     = rd_mdl_ok && (req_triangle_index < rd_cnt);
    assign rd_addr   = AW'(rd_mdl) * AW'(MAX_TRIANGLE_COUNT) + AW'(req_triangle_index);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_error_d = out_error_q;
        if (req_fire) begin
            out_valid_d = 1'b1;
            if (rd_ok) begin
                out_data_d  = mem[rd_addr];
                out_last_d  = (req_triangle_index == rd_cnt - IDX_W'(1));
                out_error_d = 1'b0;
            end else begin
                out_data_d  = '0;
                out_last_d  = 1'b1;
                out_error_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire && wr_ok)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < MAX_MODEL_COUNT; i++)
                count_q[i] <= '0;
            wr_error_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_error_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_error_q  <= wr_error_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_error_q <= out_error_d;
        end
    end

    assign wr_error  = wr_error_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_error = out_error_q;

endmodule

// File: tb/tb_model_buffer.sv
// Scoreboarded bench for model_buffer: load, read, over-fetch, backpressure,
// reload, dropped writes, read-first collision and mid-response reset.
module tb_model_buffer;

    localparam int TRI_W = 288;
    localparam int IDX_W = 16;

    typedef struct packed {
        logic [TRI_W-1:0] data;
        logic             last;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_model_index;
    logic [IDX_W-1:0] wr_triangle_index;
    logic [TRI_W-1:0] wr_data;
    logic             wr_last;
    logic             wr_error;
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_model_index;
    logic [IDX_W-1:0] req_triangle_index;
    logic             out_valid;
    logic             out_ready;
    logic [TRI_W-1:0] out_data;
    logic             out_last;
    logic             out_error;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   beats  = 0;

    always #5 clk = ~clk;

    model_buffer dut (
        .clk               (clk),
        .rstn              (rstn),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_model_index    (wr_model_index),
        .wr_triangle_index (wr_triangle_index),
        .wr_data           (wr_data),
        .wr_last           (wr_last),
        .wr_error          (wr_error),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_model_index   (req_model_index),
        .req_triangle_index(req_triangle_index),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .out_error         (out_error)
    );

    function automatic exp_t mk(input int d, input logic l, input logic e);
        exp_t x;
        x.data = TRI_W'(d);
        x.last = l;
        x.err  = e;
        return x;
    endfunction

    // All stimulus tasks start and end just after a rising edge
    task automatic write_beat(input int m, input int t, input int d, input logic l);
        wr_valid          = 1'b1;
        wr_model_index    = IDX_W'(m);
        wr_triangle_index = IDX_W'(t);
        wr_data           = TRI_W'(d);
        wr_last           = l;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic send_req(input int m, input int t, input exp_t e);
        logic r;
        int   n;
        sb_q.push_back(e);
        req_valid          = 1'b1;
        req_model_index    = IDX_W'(m);
        req_triangle_index = IDX_W'(t);
        n = 0;
        do begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 50);
        if (!r) begin
            errors++;
            checks++;
            $display("FAIL req_accept: m=%0d t=%0d not accepted in 50 cycles", m, t);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: pending=%0d out_valid=%b required 0/0",
                     sb_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_last, out_error, wr_error, wr_ready, req_ready}
            !== {1'b0, TRI_W'(0), 5'b0}) begin
            errors++;
            $display("FAIL reset_outputs: v=%b d=%h l=%b e=%b we=%b wr=%b rr=%b required all 0",
                     out_valid, out_data, out_last, out_error, wr_error, wr_ready, req_ready);
        end
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: wr_ready=%b req_ready=%b required 1/1",
                     wr_ready, req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_read();
        int b0;
        write_beat(2, 0, 'hA0, 1'b0);
        write_beat(2, 1, 'hA1, 1'b0);
        write_beat(2, 2, 'hA2, 1'b1);
        out_ready = 1'b1;
        b0 = beats;
        send_req(2, 0, mk('hA0, 1'b0, 1'b0));
        send_req(2, 1, mk('hA1, 1'b0, 1'b0));
        send_req(2, 2, mk('hA2, 1'b1, 1'b0));
        req_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || beats - b0 != 2) begin
            errors++;
            $display("FAIL back_to_back: out_valid=%b beats=%0d required 1/2",
                     out_valid, beats - b0);
        end
        wait_drain();
    endtask

    task automatic test_out_of_range();
        send_req(2, 3, mk(0, 1'b1, 1'b1));
        send_req(5, 0, mk(0, 1'b1, 1'b1));
        send_req(10, 0, mk(0, 1'b1, 1'b1));
        req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_req(2, 0, mk('hA0, 1'b0, 1'b0));
        req_valid          = 1'b1;
        req_model_index    = 16'd2;
        req_triangle_index = 16'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== TRI_W'('hA0)) begin
                errors++;
                $display("FAIL stall_%0d: rr=%b v=%b d=%h required 0/1/a0",
                         i, req_ready, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_req(2, 1, mk('hA1, 1'b0, 1'b0));
        req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_same_cycle();
        sb_q.push_back(mk('hA1, 1'b0, 1'b0));
        wr_valid           = 1'b1;
        wr_model_index     = 16'd2;
        wr_triangle_index  = 16'd1;
        wr_data            = TRI_W'('hC1);
        wr_last            = 1'b0;
        req_valid          = 1'b1;
        req_model_index    = 16'd2;
        req_triangle_index = 16'd1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL collide_ready: rr=%b wr=%b required 1/1", req_ready, wr_ready);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        send_req(2, 1, mk('hC1, 1'b0, 1'b0));
        req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_reload();
        write_beat(2, 0, 'hB0, 1'b0);
        send_req(2, 0, mk(0, 1'b1, 1'b1));
        req_valid = 1'b0;
        wait_drain();
        write_beat(2, 0, 'hB0, 1'b1);
        send_req(2, 0, mk('hB0, 1'b1, 1'b0));
        send_req(2, 1, mk(0, 1'b1, 1'b1));
        req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_write_error();
        @(negedge clk);
        checks++;
        if (wr_error !== 1'b0) begin
            errors++;
            $display("FAIL wr_error_initial: got %b required 0", wr_error);
        end
        @(posedge clk); #1;
        write_beat(10, 0, 'hDD, 1'b1);
        @(negedge clk);
        checks++;
        if (wr_error !== 1'b1) begin
            errors++;
            $display("FAIL wr_error_model: got %b required 1", wr_error);
        end
        @(posedge clk); #1;
        write_beat(0, 100, 'hEE, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (wr_error !== 1'b1) begin
            errors++;
            $display("FAIL wr_error_sticky: got %b required 1", wr_error);
        end
        @(posedge clk); #1;
        send_req(0, 0, mk(0, 1'b1, 1'b1));
        send_req(2, 0, mk('hB0, 1'b1, 1'b0));
        req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_ready          = 1'b0;
        req_valid          = 1'b1;
        req_model_index    = 16'd2;
        req_triangle_index = 16'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: got %b required 1", out_valid);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || wr_error !== 1'b0 || out_data !== TRI_W'(0)) begin
            errors++;
            $display("FAIL mid_reset: v=%b we=%b d=%h required 0/0/0",
                     out_valid, wr_error, out_data);
        end
        @(posedge clk); #1;
        rstn      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: out_valid=%b required 0", out_valid);
        end
        send_req(2, 0, mk(0, 1'b1, 1'b1));
        send_req(2, 2, mk(0, 1'b1, 1'b1));
        req_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        rstn               = 1'b1;
        wr_valid           = 1'b0;
        wr_model_index     = '0;
        wr_triangle_index  = '0;
        wr_data            = '0;
        wr_last            = 1'b0;
        req_valid          = 1'b0;
        req_model_index    = '0;
        req_triangle_index = '0;
        out_ready          = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!rstn && out_valid && out_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: d=%h l=%b e=%b required no beat",
                                 out_data, out_last, out_error);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        beats++;
                        if ({out_data, out_last, out_error} !== {e.data, e.last, e.err}) begin
                            errors++;
                            $display("FAIL beat_%0d: d=%h l=%b e=%b required d=%h l=%b e=%b",
                                     beats, out_data, out_last, out_error,
                                     e.data, e.last, e.err);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_load_read();
        test_out_of_range();
        test_backpressure();
        test_same_cycle();
        test_reload();
        test_write_error();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
